bubble_sort_seq: RTL

//   Sequential, parametrised sorter for packed arrays of unsigned elements.

---
 rtl/bubble_sort_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bubble_sort_seq.sv
// Odd-even transposition sorter, one compare/exchange phase per clock, early exit once ordered.
// Latency P in [2,DIM] cycles after accept; result held in DONE until out_ready, accepts only in IDLE.
module bubble_sort_seq #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DIM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_data,
  input  logic                 in_desc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_data,
  output logic [PW-1:0]        out_passes
);

  if (DIM < 2) begin : g_dim_check
    $error("bubble_sort_seq needs DIM >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic [DIM-1:0][WIDTH-1:0]       a;
  logic [DIM-1:0][WIDTH-1:0]       nxt;
  logic                            desc;
  logic [PW-1:0]                   phase;
  logic                            prev_swap;
  logic [DIM-2:0]                  pair_swap;
  logic                            swap;
  logic                            term;
  logic                            accept;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Pairs starting at an even index are active on even phases, odd on odd.
  for (genvar g = 0; g < DIM - 1; g++) begin : g_pair
    localparam logic PAR = ((g % 2) != 0);
    logic gt;
    logic lt;
    assign gt           = a[g] > a[g+1];
    assign lt           = a[g] < a[g+1];
    assign pair_swap[g] = (phase[0] == PAR) && (desc ? lt : gt);
  end

  always_comb begin
    nxt = a;
    for (int i = 0; i < DIM - 1; i++) begin
      if (pair_swap[i]) begin
        nxt[i]   = a[i+1];
        nxt[i+1] = a[i];
      end
    end
  end

  // Two consecutive quiet phases cover both pair parities, so the array is ordered.
  assign swap = |pair_swap;
  assign term = (!swap && !prev_swap) || (phase == PW'(DIM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SORT;
      SORT:    if (term)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a          <= '0;
      desc       <= 1'b0;
      phase      <= '0;
      prev_swap  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_passes <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a         <= in_data;
            desc      <= in_desc;
            phase     <= '0;
            prev_swap <= 1'b1;
          end
        end
        SORT: begin
          if (term) begin
            out_data   <= nxt;
            out_passes <= phase + PW'(1);
            out_valid  <= 1'b1;
          end else begin
            a         <= nxt;
            phase     <= phase + PW'(1);
            prev_swap <= swap;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
